// File: rtl/imm_dec_buf.sv
// imm_dec_buf: DEPTH-entry FIFO that decodes the RV32I immediate of each word on push
// and presents the head entry to the sign/zero-extend stage. Optional macro: IMM_ILLEGAL_DET_EN.
module imm_dec_buf #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [19:0] imm,
    output logic        sz_ex_sel,
    output logic [1:0]  sz_ex_mode
`ifdef IMM_ILLEGAL_DET_EN
    ,
    output logic        illegal
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef IMM_ILLEGAL_DET_EN
    localparam int ENT_W = 24;
`else
    localparam int ENT_W = 23;
`endif
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Entry packing: {sel, mode[1:0], imm[19:0]}
    function automatic logic [22:0] decode_imm(input logic [31:0] w);
        logic [22:0] r;
        r = 23'h0;
        case (w[6:0])
            OP_LUI, OP_AUIPC:          r = {1'b0, 2'b10, w[31:12]};
            OP_JAL:                    r = {1'b1, 2'b11, w[31], w[19:12], w[20], w[30:21]};
            OP_JALR, OP_LOAD, OP_OPIMM: r = {1'b1, 2'b00, 8'h00, w[31:20]};
            OP_STORE:                  r = {1'b1, 2'b00, 8'h00, w[31:25], w[11:7]};
            OP_BRANCH:                 r = {1'b1, 2'b01, 8'h00, w[31], w[7], w[30:25], w[11:8]};
            OP_SYSTEM: begin
                if (w[14]) begin
                    r = {1'b0, 2'b00, 15'h0, w[19:15]};
                end else begin
                    r = 23'h0;
                end
            end
            default:                   r = 23'h0;
        endcase
        return r;
    endfunction

`ifdef IMM_ILLEGAL_DET_EN
    function automatic logic illegal_op(input logic [6:0] op);
        logic r;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_OPIMM, OP_OP, OP_MISC, OP_SYSTEM: r = 1'b0;
            default:                                       r = 1'b1;
        endcase
        return r;
    endfunction
`endif

    logic [ENT_W-1:0] mem_r [DEPTH];
    logic [ENT_W-1:0] head_r;
    logic [ENT_W-1:0] head_nxt_s;
    logic [ENT_W-1:0] dec_s;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] cnt_rem_s;
    logic             push_s;
    logic             pop_s;

    // Handshakes, decode of the incoming word and next-state of count/head
    always_comb begin
        push_s     = instr_valid && instr_ready;
        pop_s      = out_valid && out_ready;
`ifdef IMM_ILLEGAL_DET_EN
        dec_s      = {illegal_op(instr[6:0]), decode_imm(instr)};
`else
        dec_s      = decode_imm(instr);
`endif
        cnt_rem_s  = pop_s ? (cnt_r - CNT_ONE) : cnt_r;
        rd_nxt_s   = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        case ({push_s, pop_s})
            2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
            2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
            default: cnt_nxt_s = cnt_r;
        endcase
        // The new word becomes head only when nothing older survives this cycle
        if (cnt_nxt_s == CNT_ZERO) begin
            head_nxt_s = '0;
        end else if (push_s && (cnt_rem_s == CNT_ZERO)) begin
            head_nxt_s = dec_s;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end
    end

    // Control state and registered head/flag outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= CNT_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            wr_ptr_r    <= PTR_ZERO;
            head_r      <= '0;
            out_valid   <= 1'b0;
            instr_ready <= 1'b1;
        end else begin
            cnt_r       <= cnt_nxt_s;
            rd_ptr_r    <= rd_nxt_s;
            wr_ptr_r    <= push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
            head_r      <= head_nxt_s;
            out_valid   <= (cnt_nxt_s != CNT_ZERO);
            instr_ready <= (cnt_nxt_s != CNT_FULL);
        end
    end

    // Entry storage, written on push
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= dec_s;
        end
    end

    assign imm        = head_r[19:0];
    assign sz_ex_mode = head_r[21:20];
    assign sz_ex_sel  = head_r[22];
`ifdef IMM_ILLEGAL_DET_EN
    assign illegal    = head_r[23];
`endif

endmodule

// File: tb/tb_imm_dec_buf.sv
// tb_imm_dec_buf: queue-based reference model checked every cycle, plus directed
// vectors with hand-computed literal expectations. Honours IMM_ILLEGAL_DET_EN.
module tb_imm_dec_buf;

    localparam int DEPTH = 2;

    typedef struct {
        logic [19:0] imm;
        logic        sel;
        logic [1:0]  mode;
        logic        ill;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] imm;
    logic        sz_ex_sel;
    logic [1:0]  sz_ex_mode;
`ifdef IMM_ILLEGAL_DET_EN
    logic        illegal;
`endif

    int   n_chk  = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;
    ent_t q[$];
    ent_t tmp_e;

    logic [31:0] vec [14] = '{
        32'h00112623, 32'hFE010113, 32'h00008067, 32'hFFC42503,
        32'h123450B7, 32'h00001097, 32'hFF5FF06F, 32'h00B50463,
        32'h00000073, 32'h00B50533, 32'h0000000F, 32'h3007D073,
        32'h0000007F, 32'h00000012
    };

    imm_dec_buf #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .imm         (imm),
        .sz_ex_sel   (sz_ex_sel),
        .sz_ex_mode  (sz_ex_mode)
`ifdef IMM_ILLEGAL_DET_EN
        ,
        .illegal     (illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode: build the architectural offset, then pick the packed field
    function automatic ent_t model_dec(input logic [31:0] w);
        ent_t        e;
        logic [6:0]  op;
        logic [20:0] j_off;
        logic [12:0] b_off;
        logic [11:0] s_off;
        op    = w[6:0];
        e     = '{imm: 20'h0, sel: 1'b0, mode: 2'b00, ill: 1'b1};
        j_off = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        b_off = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        s_off = {w[31:25], w[11:7]};
        if (op == 7'h37 || op == 7'h17) begin
            e.imm = w[31:12]; e.mode = 2'b10;
        end else if (op == 7'h6F) begin
            e.imm = j_off[20:1]; e.mode = 2'b11; e.sel = 1'b1;
        end else if (op == 7'h67 || op == 7'h03 || op == 7'h13) begin
            e.imm = 20'(w[31:20]); e.sel = 1'b1;
        end else if (op == 7'h23) begin
            e.imm = 20'(s_off); e.sel = 1'b1;
        end else if (op == 7'h63) begin
            e.imm = 20'(b_off[12:1]); e.mode = 2'b01; e.sel = 1'b1;
        end else if (op == 7'h73 && w[14]) begin
            e.imm = 20'(w[19:15]);
        end
        if (op == 7'h37 || op == 7'h17 || op == 7'h6F || op == 7'h67 || op == 7'h63 ||
            op == 7'h03 || op == 7'h23 || op == 7'h13 || op == 7'h33 || op == 7'h0F ||
            op == 7'h73)
            e.ill = 1'b0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic lit(input string name, input logic ov, input logic ir,
                       input logic [19:0] im, input logic sel, input logic [1:0] md);
        chk({name, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({name, ".instr_ready"}, 32'(instr_ready), 32'(ir));
        chk({name, ".imm"}, 32'(imm), 32'(im));
        chk({name, ".sel"}, 32'(sz_ex_sel), 32'(sel));
        chk({name, ".mode"}, 32'(sz_ex_mode), 32'(md));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state update
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
        end else if (instr_valid && q.size() < DEPTH) begin
            if (out_ready && q.size() != 0) void'(q.pop_front());
            q.push_back(model_dec(instr));
        end else if (out_ready && q.size() != 0) begin
            void'(q.pop_front());
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m.out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("m.instr_ready", 32'(instr_ready), 32'(q.size() != DEPTH));
            chk("m.imm", 32'(imm), (q.size() != 0) ? 32'(q[0].imm) : 32'h0);
            chk("m.sel", 32'(sz_ex_sel), (q.size() != 0) ? 32'(q[0].sel) : 32'h0);
            chk("m.mode", 32'(sz_ex_mode), (q.size() != 0) ? 32'(q[0].mode) : 32'h0);
`ifdef IMM_ILLEGAL_DET_EN
            chk("m.illegal", 32'(illegal), (q.size() != 0) ? 32'(q[0].ill) : 32'h0);
`endif
        end
    end

    initial begin
        rst = 1'b1; instr_valid = 1'b0; out_ready = 1'b0; instr = 32'h0;

        tmp_e = model_dec(32'hFF5FF06F);
        chk("mdl_jal.imm", 32'(tmp_e.imm), 32'h000FFFFA);
        tmp_e = model_dec(32'h00112623);
        chk("mdl_sw.imm", 32'(tmp_e.imm), 32'h0000000C);
        tmp_e = model_dec(32'hFE000EE3);
        chk("mdl_beq.imm", 32'(tmp_e.imm), 32'h00000FFE);
        chk("mdl_beq.mode", 32'(tmp_e.mode), 32'h1);

        tick();
        chk_en = 1'b1;
        @(negedge clk) rst = 1'b0;
        tick(); lit("reset", 1'b0, 1'b1, 20'h0, 1'b0, 2'b00);

        // addi x1,x0,-1
        @(negedge clk) begin instr_valid = 1'b1; instr = 32'hFFF00093; out_ready = 1'b1; end
        tick(); lit("addi", 1'b1, 1'b1, 20'h00FFF, 1'b1, 2'b00);
        @(negedge clk) instr_valid = 1'b0;
        tick(); lit("addi_pop", 1'b0, 1'b1, 20'h0, 1'b0, 2'b00);

        // lui then beq -4, consumer stalled until both are in
        @(negedge clk) begin out_ready = 1'b0; instr_valid = 1'b1; instr = 32'hFFFFF0B7; end
        tick(); lit("lui", 1'b1, 1'b1, 20'hFFFFF, 1'b0, 2'b10);
        @(negedge clk) instr = 32'hFE000EE3;
        tick(); lit("lui_full", 1'b1, 1'b0, 20'hFFFFF, 1'b0, 2'b10);
        @(negedge clk) begin instr_valid = 1'b0; out_ready = 1'b1; end
        tick(); lit("beq", 1'b1, 1'b1, 20'h00FFE, 1'b1, 2'b01);
        tick(); lit("drained", 1'b0, 1'b1, 20'h0, 1'b0, 2'b00);

        // full buffer holds off a third word until one pop
        @(negedge clk) begin out_ready = 1'b0; instr_valid = 1'b1; instr = 32'h0000006F; end
        tick(); lit("jal", 1'b1, 1'b1, 20'h0, 1'b1, 2'b11);
        @(negedge clk) instr = 32'h00000013;
        tick(); lit("jal_full", 1'b1, 1'b0, 20'h0, 1'b1, 2'b11);
        @(negedge clk) instr = 32'h00100093;
        tick(); lit("third_held", 1'b1, 1'b0, 20'h0, 1'b1, 2'b11);
        @(negedge clk) out_ready = 1'b1;
        tick(); lit("after_pop", 1'b1, 1'b1, 20'h0, 1'b1, 2'b00);
        @(negedge clk) out_ready = 1'b0;
        tick(); lit("third_in", 1'b1, 1'b0, 20'h0, 1'b1, 2'b00);

        // reset beats simultaneous push and pop on a full buffer
        @(negedge clk) begin rst = 1'b1; out_ready = 1'b1; end
        tick(); lit("rst_full", 1'b0, 1'b1, 20'h0, 1'b0, 2'b00);
        @(negedge clk) begin rst = 1'b0; instr_valid = 1'b0; out_ready = 1'b0; end
        tick(); lit("rst_after", 1'b0, 1'b1, 20'h0, 1'b0, 2'b00);

        // unsupported opcode, then csrwi with zimm 0
        @(negedge clk) begin instr_valid = 1'b1; instr = 32'h0000007F; out_ready = 1'b1; end
        tick(); lit("unknown", 1'b1, 1'b1, 20'h0, 1'b0, 2'b00);
`ifdef IMM_ILLEGAL_DET_EN
        chk("unknown.illegal", 32'(illegal), 32'h1);
`endif
        @(negedge clk) instr = 32'h00005073;
        tick(); lit("csrwi", 1'b1, 1'b1, 20'h0, 1'b0, 2'b00);
`ifdef IMM_ILLEGAL_DET_EN
        chk("csrwi.illegal", 32'(illegal), 32'h0);
`endif

        // mixed traffic exercising pointer wrap and back-pressure
        for (int i = 0; i < 42; i++) begin
            @(negedge clk) begin
                instr_valid = ((i % 3) != 2);
                out_ready   = ((i % 4) != 0);
                instr       = vec[i % 14];
            end
        end
        @(negedge clk) begin instr_valid = 1'b0; out_ready = 1'b1; end
        repeat (4) tick();
        lit("final", 1'b0, 1'b1, 20'h0, 1'b0, 2'b00);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_dec_buf.md
IMM_DEC_BUF -- requirements
Module: imm_dec_buf

Interface
REQ-001 SHALL have parameter: DEPTH, 2, number of buffer entries (power of two, 2..8).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: instr_valid  input  1  producer has an instruction word.
REQ-005 SHALL have port: instr_ready  output  1  buffer can accept one word this cycle.
REQ-006 SHALL have port: instr  input  32  RV32I instruction word.
REQ-007 SHALL have port: out_valid  output  1  head entry holds a decoded immediate.
REQ-008 SHALL have port: out_ready  input  1  consumer (extender stage) takes head entry.
REQ-009 SHALL have port: imm  output  20  packed immediate field for the sign/zero-extend stage.
REQ-010 SHALL have port: sz_ex_sel  output  1  1 = sign extend, 0 = zero extend.
REQ-011 SHALL have port: sz_ex_mode  output  2  00 STANDARD, 01 BRANCH, 10 U_TYPE, 11 JAL.
REQ-012 SHALL have port: illegal  output  1  head opcode unsupported (present only with IMM_ILLEGAL_DET_EN).

Function
REQ-013 Push SHALL occur when instr_valid and instr_ready are both high; pop when out_valid and out_ready are both high.
REQ-014 Decode SHALL be computed on push and stored; head-entry fields SHALL appear on outputs the cycle after push into an empty buffer (latency 1).
REQ-015 instr_ready SHALL equal (count != DEPTH); out_valid SHALL equal (count != 0); both derived from registered count only.
REQ-016 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and preserve order.
REQ-017 When full, instr_ready SHALL be low even if out_ready is high that cycle; it rises the cycle after the pop.
REQ-018 Read/write pointers SHALL wrap modulo DEPTH.
REQ-019 Outputs SHALL hold stable while out_valid high and out_ready low.
REQ-020 LUI/AUIPC: imm = instr[31:12], mode U_TYPE, sel 0.
REQ-021 JAL: imm = {instr[31],instr[19:12],instr[20],instr[30:21]}, mode JAL, sel 1.
REQ-022 JALR/LOAD/OP-IMM: imm = {8'h00,instr[31:20]}, mode STANDARD, sel 1.
REQ-023 STORE: imm = {8'h00,instr[31:25],instr[11:7]}, mode STANDARD, sel 1.
REQ-024 BRANCH: imm = {8'h00,instr[31],instr[7],instr[30:25],instr[11:8]}, mode BRANCH, sel 1.
REQ-025 SYSTEM with funct3[2]=1: imm = {15'h0,instr[19:15]}, mode STANDARD, sel 0; other SYSTEM, OP, FENCE and unknown opcodes: imm 0, mode STANDARD, sel 0.
REQ-026 When out_valid low, imm, sz_ex_sel, sz_ex_mode (and illegal) SHALL be 0.

Reset
REQ-027 rst high at a rising edge SHALL set count and both pointers to 0, forcing out_valid 0, instr_ready 1, all data outputs 0 the next cycle.
REQ-028 rst SHALL override any push or pop in the same cycle; buffered entries are discarded.
REQ-029 Entry storage SHALL need no reset; only control state is reset.

Configuration
REQ-030 Macro IMM_ILLEGAL_DET_EN defined: illegal port exists; stored per entry; 1 for opcodes outside LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM, or instr[1:0] != 2'b11.
REQ-031 Macro undefined: no illegal port or storage; decode otherwise identical.

Verification
REQ-032 Push 32'hFFF00093 (addi, imm -1), out_ready 1 -> next cycle out_valid 1, imm 20'h00FFF, sel 1, mode 00.
REQ-033 Push 32'hFFFFF0B7 (lui) then 32'hFE000EE3 (beq, offset -4) -> imm 20'hFFFFF/mode 10/sel 0, then imm 20'h00FFE/mode 01/sel 1, in order.
REQ-034 out_ready 0, push 32'h0000006F, 32'h00000013, third word offered -> instr_ready 0 after two pushes, third held; out_ready 1 one cycle -> instr_ready 1 next cycle, JAL entry (imm 0, mode 11) popped first.
REQ-035 Buffer full, assert rst one cycle with instr_valid and out_ready high -> next cycle out_valid 0, instr_ready 1, imm 0; no entry retained.
REQ-036 With IMM_ILLEGAL_DET_EN, push 32'h0000007F -> illegal 1, imm 0, mode 00; push 32'h00005073 (csrwi, zimm 0) -> illegal 0, sel 0.
